serializer: RTL and testbench
=============================

# serializer

Parallel-to-serial converter that feeds the `deserializer` stage over a one-bit data/valid pair. It accepts a `DATA_W`-bit word with a bit-count modifier and emits the selected bits MSB-first, one per clock. A one-word pending slot lets consecutive words go out back-to-back with no idle cycle between them, so the downstream `deserializer` sees a contiguous bit stream.

## Interface
- `DATA_W`, 16, word width; a power of two, ≥ 4.
- `MOD_W`, `$clog2(DATA_W)`, width of the bit-count modifier.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `srst_i`  in  1  reset, synchronous and active-high.
- `data_i`  in  DATA_W  parallel word.
- `data_mod_i`  in  MOD_W  number of bits to send; 0 means all `DATA_W` bits.
- `data_val_i`  in  1  `data_i`/`data_mod_i` valid this cycle.
- `ser_data_o`  out  1  serial bit.
- `ser_data_val_o`  out  1  `ser_data_o` valid.
- `busy_o`  out  1  pending slot occupied; input is not accepted.

## Operation
- Storage: active shift register, active bit counter, and a pending slot (word, length, valid flag).
- Transmit order: MSB-first.
  - For length L, send `data_i[DATA_W-1]` down to `data_i[DATA_W-L]`.
  - Lower bits are never sent.
- Length rule:
  - `data_mod_i` = 0 → L = `DATA_W`.
  - `data_mod_i` = 1 or 2 → word is dropped: not accepted, no bits sent, no state change.
  - Any other value → L = `data_mod_i`.
- Accept condition: `data_val_i` && !`busy_o` && L valid.
- Routing of an accepted word:
  - Goes to the active register if the engine is IDLE, or if it is sending its last bit this cycle and the pending slot is empty.
  - Otherwise goes to the pending slot.
- Word completion:
  - When the last bit of the active word is sent and the pending slot is full, the pending word moves to the active register on the same edge.
  - The pending slot is cleared on that edge.
- `data_val_i` while `busy_o` = 1 is ignored; the word is lost. Upstream must hold off.
- FSM states:
  - IDLE → SEND on accept.
  - SEND → SEND while bits remain, or when a next word is available (pending slot or direct accept).
  - SEND → IDLE after the last bit when no word is available.
- `ser_data_o` is driven 0 whenever `ser_data_val_o` = 0.

## Timing
- Reset values: `ser_data_o` = 0, `ser_data_val_o` = 0, `busy_o` = 0; FSM in IDLE; pending slot invalid.
- All outputs are registered.
- Latency: word accepted at edge N → first bit on `ser_data_o` with `ser_data_val_o` = 1 in cycle N+1.
  - Following bits appear in consecutive cycles.
  - A word of length L occupies exactly L valid cycles.
- Back-to-back: the first bit of the next word follows the last bit of the current word in the very next cycle, with no valid gap.
- `busy_o` reflects the registered pending-valid flag:
  - Rises the cycle after a word is written into the pending slot.
  - Falls the cycle after the pending word moves to active.
- Reset mid-operation: `srst_i` high at edge N clears all state.
  - Outputs are at reset values from cycle N+1.
  - The partial word is discarded; no further bits are sent.
  - `srst_i` has priority over `data_val_i` in the same cycle.

## Structure
- Package `serializer_pkg`:
  - `DATA_W` default, `MOD_W`.
  - State enum `ser_state_t` {IDLE, SEND}.
  - Constants `MOD_FULL` = 0, `MOD_MIN` = 3.
- Sub-module `ser_pending_slot`: holds word, length and valid flag, with load/unload strobes; drives `busy_o`.
- The top level holds the FSM, shift register and bit counter.
- Output is directly compatible with `deserializer` inputs: `ser_data_o` → `data_i`, `ser_data_val_o` → `data_val_i`.

## Test plan
- Full word: `data_i` = 16'hA5C3, mod 0, single valid pulse → 16 consecutive valid bits 1010_0101_1100_0011 starting 1 cycle later; a downstream `deserializer` outputs 16'hA5C3.
- Short word: 16'hF000, mod 5 → 5 valid bits 1,1,1,1,0, then `ser_data_val_o` = 0 and IDLE.
- Illegal mods: mod 1 and mod 2 pulses → no valid output, `busy_o` stays 0.
- Streaming: 16'h1234, 16'h5678, 16'h9ABC offered whenever `busy_o` = 0 → 48 uninterrupted valid bits in order; `busy_o` high only while a word is pending.
- Valid while busy: `data_val_i` with 16'hFFFF while `busy_o` = 1 → word not sent; the stream contains only previously accepted words.
- Reset mid-word: `srst_i` after 7 bits of 16'hAAAA → outputs 0 the next cycle, no further bits; a new word after reset is sent from its MSB.

Source files
------------

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared constants and types for the serializer
package serializer_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_MOD_W  = $clog2(DEF_DATA_W);

    // A modifier of MOD_FULL sends the whole word; lengths below MOD_MIN are rejected.
    localparam int MOD_FULL = 0;
    localparam int MOD_MIN  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_pending_slot.sv
// rtl/ser_pending_slot.sv - one-word holding slot between input and shift engine
module ser_pending_slot #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    output logic [DATA_W-1:0] o_data,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_len;
    logic              r_valid;

    // Capture a word on load; drop the valid flag when the engine takes it.
    // Load and unload never coincide: load needs an empty slot, unload a full one.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_data  <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_len   <= i_len;
            r_valid <= 1'b1;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_len   = r_len;
    assign o_valid = r_valid;

endmodule

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter, MSB-first, with one-word lookahead
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam int LEN_W = MOD_W + 1;

    ser_state_t        r_state;
    ser_state_t        w_next_state;
    logic [DATA_W-1:0] r_shift;
    logic [LEN_W-1:0]  r_cnt;        // bits still to send after the one on the output
    logic              r_ser_data;
    logic              r_ser_val;

    logic [LEN_W-1:0]  w_len;
    logic              w_len_ok;
    logic              w_accept;
    logic              w_last;
    logic              w_direct;
    logic              w_pend_load;
    logic              w_pend_unload;
    logic              w_pend_val;
    logic [DATA_W-1:0] w_pend_data;
    logic [LEN_W-1:0]  w_pend_len;
    logic              w_load;
    logic [DATA_W-1:0] w_load_word;
    logic [LEN_W-1:0]  w_load_len;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic              w_ser_data_nxt;
    logic              w_ser_val_nxt;

    assign w_len    = (data_mod_i == MOD_W'(MOD_FULL)) ? LEN_W'(DATA_W) : {1'b0, data_mod_i};
    assign w_len_ok = (data_mod_i == MOD_W'(MOD_FULL)) || (data_mod_i >= MOD_W'(MOD_MIN));
    assign w_accept = data_val_i && !w_pend_val && w_len_ok;

    // The bit currently on the output is the final one of the active word.
    assign w_last        = (r_state == SEND) && (r_cnt == '0);
    assign w_direct      = w_accept && ((r_state == IDLE) || (w_last && !w_pend_val));
    assign w_pend_load   = w_accept && !w_direct;
    assign w_pend_unload = w_last && w_pend_val;

    // A waiting pending word always wins over the input port.
    assign w_load      = w_pend_unload || w_direct;
    assign w_load_word = w_pend_unload ? w_pend_data : data_i;
    assign w_load_len  = w_pend_unload ? w_pend_len  : w_len;

    ser_pending_slot #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_pending (
        .i_clk    (clk_i),
        .i_srst   (srst_i),
        .i_load   (w_pend_load),
        .i_unload (w_pend_unload),
        .i_data   (data_i),
        .i_len    (w_len),
        .o_data   (w_pend_data),
        .o_len    (w_pend_len),
        .o_valid  (w_pend_val)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: stay in SEND while bits remain or another word is ready to chain on.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = SEND;
            SEND:    if (w_last && !w_load) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Next output/datapath values: load a fresh word, shift the active one, or go quiet.
    always_comb begin
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_ser_data_nxt = 1'b0;
        w_ser_val_nxt  = 1'b0;
        if (w_load) begin
            w_ser_data_nxt = w_load_word[DATA_W-1];
            w_ser_val_nxt  = 1'b1;
            w_shift_nxt    = w_load_word << 1;
            w_cnt_nxt      = w_load_len - LEN_W'(1);
        end else if ((r_state == SEND) && !w_last) begin
            w_ser_data_nxt = r_shift[DATA_W-1];
            w_ser_val_nxt  = 1'b1;
            w_shift_nxt    = r_shift << 1;
            w_cnt_nxt      = r_cnt - LEN_W'(1);
        end
    end

    // Register the datapath and the outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ser_data <= 1'b0;
            r_ser_val  <= 1'b0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ser_data <= w_ser_data_nxt;
            r_ser_val  <= w_ser_val_nxt;
        end
    end

    assign ser_data_o     = r_ser_data;
    assign ser_data_val_o = r_ser_val;
    assign busy_o         = w_pend_val;

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for serializer
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic [15:0] data_i = '0;
    logic [3:0]  data_mod_i = '0;
    logic        data_val_i = 1'b0;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    serializer dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_val"},  48'(ser_data_val_o), 48'd0);
        chk({tag, "_data"}, 48'(ser_data_o),     48'd0);
        chk({tag, "_busy"}, 48'(busy_o),         48'd0);
    endtask

    // One word from idle; the bits are reassembled as a downstream deserializer would.
    task automatic send_single(input string tag, input logic [15:0] word,
                               input logic [3:0] md, input int len);
        logic [15:0] got;
        got = '0;
        data_i = word; data_mod_i = md; data_val_i = 1'b1;
        step();
        data_val_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            chk({tag, "_val"}, 48'(ser_data_val_o), 48'd1);
            chk({tag, "_bit"}, 48'(ser_data_o), 48'(word[15-i]));
            got = {got[14:0], ser_data_o};
            step();
        end
        chk({tag, "_word"}, 48'(got), 48'(word >> (16 - len)));
        chk_idle({tag, "_end"});
    endtask

    initial begin
        logic [47:0] exp_bits;
        logic [15:0] words [3];
        int          idx;
        bit          exp_busy;

        step(); step();
        chk_idle("reset");
        srst_i = 1'b0;
        step();
        chk_idle("post_reset");

        send_single("full", 16'hA5C3, 4'd0, 16);
        send_single("short", 16'hF000, 4'd5, 5);

        // Illegal modifiers are silently dropped.
        data_i = 16'hFFFF; data_mod_i = 4'd1; data_val_i = 1'b1;
        step();
        chk_idle("mod1");
        data_mod_i = 4'd2;
        step();
        chk_idle("mod2");
        data_val_i = 1'b0;
        step();
        chk_idle("mod_after");

        // Streaming: three words offered whenever busy_o is low.
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
        exp_bits = 48'h123456789ABC;
        data_i = words[0]; data_mod_i = 4'd0; data_val_i = 1'b1;
        idx = 1;
        step();
        for (int cyc = 1; cyc <= 50; cyc++) begin
            exp_busy = (cyc >= 2 && cyc <= 16) || (cyc >= 18 && cyc <= 32);
            chk("stream_busy", 48'(busy_o), 48'(exp_busy));
            chk("stream_val", 48'(ser_data_val_o), 48'(cyc <= 48));
            chk("stream_bit", 48'(ser_data_o), (cyc <= 48) ? 48'(exp_bits[48-cyc]) : 48'd0);
            if (!busy_o && idx < 3) begin
                data_i = words[idx]; data_val_i = 1'b1; idx++;
            end else begin
                data_val_i = 1'b0;
            end
            step();
        end
        data_val_i = 1'b0;

        // Valid while busy: the 16'hFFFF offered during busy must never appear.
        exp_bits = {16'h0F0F, 16'h3C3C, 16'h0000};
        data_i = 16'h0F0F; data_mod_i = 4'd0; data_val_i = 1'b1;
        step();
        data_i = 16'h3C3C;
        step();
        chk("vwb_busy_rise", 48'(busy_o), 48'd1);
        data_i = 16'hFFFF;
        step();
        data_val_i = 1'b0;
        for (int cyc = 3; cyc <= 35; cyc++) begin
            chk("vwb_val", 48'(ser_data_val_o), 48'(cyc <= 32));
            chk("vwb_bit", 48'(ser_data_o), (cyc <= 32) ? 48'(exp_bits[48-cyc]) : 48'd0);
            step();
        end
        chk("vwb_busy_end", 48'(busy_o), 48'd0);

        // Reset after 7 bits of 16'hAAAA, with a competing valid word in the reset cycle.
        data_i = 16'hAAAA; data_mod_i = 4'd0; data_val_i = 1'b1;
        step();
        data_val_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("rst_pre_val", 48'(ser_data_val_o), 48'd1);
            chk("rst_pre_bit", 48'(ser_data_o), 48'((i % 2) == 0));
            if (i == 6) begin
                srst_i = 1'b1; data_i = 16'h7777; data_val_i = 1'b1;
            end
            step();
        end
        srst_i = 1'b0; data_val_i = 1'b0;
        chk_idle("rst_cut");
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("rst_quiet");
        end
        send_single("after_rst", 16'h8001, 4'd4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
